// File: rtl/i2s_link_ctrl.sv
// Link controller for the I2S slave: sequences bring-up, rate changes and
// loss-of-frame recovery, owning the I2S rate select and active-low reset.
module i2s_link_ctrl #(
   parameter int RATE_W      = 3,
   parameter int RATE_MAX    = 1,
   parameter int QUIESCE_CYC = 64,
   parameter int SETTLE_CYC  = 256,
   parameter int LOCK_FRAMES = 4,
   parameter int LOCK_TO_CYC = 65536,
   parameter int WD_CYC      = 8192,
   parameter int MAX_RETRY   = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [RATE_W-1:0] req_rate,
   output logic              req_ready,
   output logic              req_done,
   output logic              req_err,
   input  logic              LRCLK,
   input  logic              sync,
   output logic [RATE_W-1:0] s_rate,
   output logic              i2s_nreset,
   output logic              link_up,
   output logic              fail,
   output logic [7:0]        relock_cnt
);

   localparam int M1   = (QUIESCE_CYC > SETTLE_CYC) ? QUIESCE_CYC : SETTLE_CYC;
   localparam int M2   = (LOCK_TO_CYC > WD_CYC) ? LOCK_TO_CYC : WD_CYC;
   localparam int MAXC = (M1 > M2) ? M1 : M2;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int LW   = $clog2(LOCK_FRAMES + 1);
   localparam int RW   = $clog2(MAX_RETRY + 1);

   localparam logic [CW-1:0]     Q_END  = CW'(QUIESCE_CYC - 1);
   localparam logic [CW-1:0]     S_END  = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0]     TO_END = CW'(LOCK_TO_CYC - 1);
   localparam logic [CW-1:0]     WD_END = CW'(WD_CYC - 1);
   localparam logic [LW-1:0]     LK_END = LW'(LOCK_FRAMES - 1);
   localparam logic [RW-1:0]     RT_END = RW'(MAX_RETRY - 1);
   localparam logic [RATE_W-1:0] RMAX   = RATE_W'(RATE_MAX);

   typedef enum logic [2:0] {
      ST_QUIESCE, ST_SWITCH, ST_SETTLE, ST_WAIT_LOCK, ST_RUN, ST_FAIL
   } state_t;

   state_t            state, state_nx;
   logic [CW-1:0]     cnt;
   logic [LW-1:0]     lock_cnt;
   logic [RW-1:0]     retry;
   logic [RATE_W-1:0] pend_rate;
   logic              req_pend;
   logic              lr_s1, lr_s2, lr_s3, sy_s1, sy_s2;
   logic              lr_edge, lr_rise;
   logic              accept, acc_ok, acc_bad, wd_exp;

   // LRCLK and sync cross from the I2S domain; third LRCLK flop is for edge detect
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lr_s1 <= 1'b0;
         lr_s2 <= 1'b0;
         lr_s3 <= 1'b0;
         sy_s1 <= 1'b0;
         sy_s2 <= 1'b0;
      end else begin
         lr_s1 <= LRCLK;
         lr_s2 <= lr_s1;
         lr_s3 <= lr_s2;
         sy_s1 <= sync;
         sy_s2 <= sy_s1;
      end
   end

   assign lr_edge = lr_s2 ^ lr_s3;
   assign lr_rise = lr_s2 & ~lr_s3;
   assign accept  = req_valid & req_ready;
   assign acc_ok  = accept & (req_rate <= RMAX);
   assign acc_bad = accept & (req_rate > RMAX);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_QUIESCE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      i2s_nreset = 1'b0;
      link_up    = 1'b0;
      req_ready  = 1'b0;
      fail       = 1'b0;
      wd_exp     = 1'b0;
      case (state)
         ST_QUIESCE: if (cnt == Q_END) state_nx = ST_SWITCH;
         ST_SWITCH:  state_nx = ST_SETTLE;
         ST_SETTLE:  if (cnt == S_END) state_nx = ST_WAIT_LOCK;
         ST_WAIT_LOCK: begin
            i2s_nreset = 1'b1;
            if (lr_rise && sy_s2 && lock_cnt == LK_END)
               state_nx = ST_RUN;
            else if (cnt == TO_END)
               state_nx = (retry < RT_END) ? ST_QUIESCE : ST_FAIL;
         end
         ST_RUN: begin
            i2s_nreset = 1'b1;
            link_up    = 1'b1;
            req_ready  = 1'b1;
            // a request arriving with watchdog expiry takes priority
            if (acc_ok) state_nx = ST_QUIESCE;
            else if (!lr_edge && cnt == WD_END) begin
               state_nx = ST_QUIESCE;
               wd_exp   = 1'b1;
            end
         end
         ST_FAIL: begin
            fail      = 1'b1;
            req_ready = 1'b1;
            if (acc_ok) state_nx = ST_QUIESCE;
         end
         default: state_nx = ST_QUIESCE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         lock_cnt   <= '0;
         retry      <= '0;
         pend_rate  <= '0;
         req_pend   <= 1'b0;
         s_rate     <= '0;
         req_done   <= 1'b0;
         req_err    <= 1'b0;
         relock_cnt <= 8'd0;
      end else begin
         req_done <= 1'b0;
         req_err  <= acc_bad;

         // one counter serves every timed state; in RUN it is the watchdog
         if (state_nx != state)               cnt <= '0;
         else if (state == ST_RUN && lr_edge) cnt <= '0;
         else                                 cnt <= cnt + CW'(1);

         if (state != ST_WAIT_LOCK) lock_cnt <= '0;
         else if (lr_rise)          lock_cnt <= sy_s2 ? lock_cnt + LW'(1) : '0;

         if (state == ST_QUIESCE && state_nx == ST_SWITCH) s_rate <= pend_rate;

         if (acc_ok) begin
            pend_rate <= req_rate;
            retry     <= '0;
            req_pend  <= 1'b1;
         end else if (state == ST_WAIT_LOCK) begin
            if (state_nx == ST_RUN) begin
               retry    <= '0;
               req_done <= req_pend;
               req_pend <= 1'b0;
            end else if (state_nx != ST_WAIT_LOCK) begin
               retry <= retry + RW'(1);
            end
         end

         if (wd_exp) begin
            pend_rate <= s_rate;
            if (relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_i2s_link_ctrl.sv
// Directed bench for i2s_link_ctrl; lock timeout is shortened so the
// three-retry failure path fits in a short run.
module tb_i2s_link_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic [2:0] req_rate = 3'd0;
   logic       LRCLK = 1'b0;
   logic       sync = 1'b1;
   logic       req_ready, req_done, req_err, i2s_nreset, link_up, fail;
   logic [2:0] s_rate;
   logic [7:0] relock_cnt;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int done_cnt = 0;
   int nr_rises = 0;
   logic prev_nr = 1'b0;
   bit   lr_en = 1'b1;
   int   lr_div = 0;
   int   last_edge = 0;

   i2s_link_ctrl #(.LOCK_TO_CYC(4096)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_rate(req_rate), .req_ready(req_ready),
      .req_done(req_done), .req_err(req_err),
      .LRCLK(LRCLK), .sync(sync),
      .s_rate(s_rate), .i2s_nreset(i2s_nreset), .link_up(link_up),
      .fail(fail), .relock_cnt(relock_cnt)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc     <= cyc + 1;
      prev_nr <= i2s_nreset;
      if (req_done) done_cnt <= done_cnt + 1;
      if (i2s_nreset && !prev_nr) nr_rises <= nr_rises + 1;
   end

   // LRCLK toggles every 32 clocks while enabled
   initial forever begin
      @(posedge clock);
      #1;
      if (lr_en) begin
         if (lr_div == 31) begin
            LRCLK     = ~LRCLK;
            lr_div    = 0;
            last_edge = cyc;
         end else lr_div++;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_link(input string tag, input int bound);
      int n;
      n = 0;
      while (link_up !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, link_up}, 32'd1);
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_s_rate"}, {29'd0, s_rate}, 32'd0);
      chk({pfx, "_nreset"}, {31'd0, i2s_nreset}, 32'd0);
      chk({pfx, "_link_up"}, {31'd0, link_up}, 32'd0);
      chk({pfx, "_req_ready"}, {31'd0, req_ready}, 32'd0);
      chk({pfx, "_req_done"}, {31'd0, req_done}, 32'd0);
      chk({pfx, "_req_err"}, {31'd0, req_err}, 32'd0);
      chk({pfx, "_fail"}, {31'd0, fail}, 32'd0);
      chk({pfx, "_relock"}, {24'd0, relock_cnt}, 32'd0);
   endtask

   initial begin
      int d0, nr0, dly, n, tgt;

      // reset state and power-up bring-up
      ticks(3);
      chk_reset_vals("por");
      reset = 1'b0;
      ticks(320);
      chk("boot_nreset_low", {31'd0, i2s_nreset}, 32'd0);
      chk("boot_rate", {29'd0, s_rate}, 32'd0);
      tick();
      chk("boot_nreset_rise", {31'd0, i2s_nreset}, 32'd1);
      wait_link("boot_lock", 2000);
      chk("boot_rate_run", {29'd0, s_rate}, 32'd0);
      ticks(2);
      chk("boot_no_done", done_cnt, 32'd0);

      // rate change to 1
      req_valid = 1'b1;
      req_rate  = 3'd1;
      chk("acc_ready", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      chk("acc_ready_drop", {31'd0, req_ready}, 32'd0);
      chk("acc_nreset_low", {31'd0, i2s_nreset}, 32'd0);
      ticks(63);
      chk("acc_rate_hold", {29'd0, s_rate}, 32'd0);
      tick();
      chk("acc_rate_new", {29'd0, s_rate}, 32'd1);
      ticks(256);
      chk("acc_nreset_hold", {31'd0, i2s_nreset}, 32'd0);
      tick();
      chk("acc_nreset_rise", {31'd0, i2s_nreset}, 32'd1);
      d0 = done_cnt;
      wait_link("acc_lock", 2000);
      ticks(2);
      chk("acc_done_once", done_cnt - d0, 32'd1);

      // out-of-range request
      req_valid = 1'b1;
      req_rate  = 3'd5;
      tick();
      req_valid = 1'b0;
      chk("bad_err", {31'd0, req_err}, 32'd1);
      chk("bad_link", {31'd0, link_up}, 32'd1);
      chk("bad_rate", {29'd0, s_rate}, 32'd1);
      chk("bad_ready", {31'd0, req_ready}, 32'd1);
      tick();
      chk("bad_err_pulse", {31'd0, req_err}, 32'd0);

      // loss of frame
      #2 lr_en = 1'b0;
      n = 0;
      while (link_up === 1'b1 && n < 10000) begin
         tick();
         n++;
      end
      dly = cyc - last_edge;
      chk("wd_fell", {31'd0, link_up}, 32'd0);
      chk("wd_delay", {31'd0, (dly >= 8192 && dly <= 8198)}, 32'd1);
      chk("wd_relock", {24'd0, relock_cnt}, 32'd1);
      chk("wd_rate", {29'd0, s_rate}, 32'd1);
      #2 lr_en = 1'b1;
      d0 = done_cnt;
      wait_link("wd_relock_lock", 2000);
      ticks(2);
      chk("wd_no_done", done_cnt - d0, 32'd0);
      chk("wd_rate_run", {29'd0, s_rate}, 32'd1);

      // request lands on the watchdog expiry cycle
      #2 lr_en = 1'b0;
      tgt = last_edge + dly - 1;
      n = 0;
      while (cyc < tgt && n < 10000) begin
         tick();
         n++;
      end
      chk("coinc_run", {31'd0, link_up}, 32'd1);
      req_valid = 1'b1;
      req_rate  = 3'd0;
      tick();
      req_valid = 1'b0;
      chk("coinc_link", {31'd0, link_up}, 32'd0);
      chk("coinc_ready", {31'd0, req_ready}, 32'd0);
      chk("coinc_relock", {24'd0, relock_cnt}, 32'd1);
      ticks(64);
      chk("coinc_rate", {29'd0, s_rate}, 32'd0);

      // reset during SETTLE
      ticks(10);
      #2 reset = 1'b1;
      #1;
      chk_reset_vals("mid");
      tick();
      reset = 1'b0;

      // sync held low: three lock timeouts then FAIL
      sync = 1'b0;
      #2 lr_en = 1'b1;
      nr0 = nr_rises;
      n = 0;
      while (fail !== 1'b1 && n < 20000) begin
         tick();
         n++;
      end
      chk("to_fail", {31'd0, fail}, 32'd1);
      chk("to_nreset", {31'd0, i2s_nreset}, 32'd0);
      chk("to_ready", {31'd0, req_ready}, 32'd1);
      chk("to_link", {31'd0, link_up}, 32'd0);
      chk("to_attempts", nr_rises - nr0, 32'd3);
      sync      = 1'b1;
      req_valid = 1'b1;
      req_rate  = 3'd1;
      tick();
      req_valid = 1'b0;
      chk("fail_clear", {31'd0, fail}, 32'd0);
      chk("fail_ready", {31'd0, req_ready}, 32'd0);
      d0 = done_cnt;
      wait_link("fail_relock", 2000);
      chk("fail_rate", {29'd0, s_rate}, 32'd1);
      ticks(2);
      chk("fail_done", done_cnt - d0, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
